// File: rtl/ram16x8s_fifo_ctrl.sv
// Valid/ready FIFO sequencer around a 16x8 single-port distributed RAM.
// 16 bytes live in the RAM and one in the RD_DATA output register, for 17 in all.
module ram16x8s_fifo_ctrl (
  input  logic       WCLK,
  input  logic       RST_N,
  input  logic       WR_VALID,
  input  logic [7:0] WR_DATA,
  output logic       WR_READY,
  output logic       RD_VALID,
  output logic [7:0] RD_DATA,
  input  logic       RD_READY,
  output logic [3:0] A,
  output logic [7:0] D,
  output logic       WE,
  input  logic [7:0] O,
  output logic [4:0] COUNT,
  output logic       FULL,
  output logic       EMPTY
);

  typedef enum logic {PRIO_RD = 1'b0, PRIO_WR = 1'b1} prio_e;

  logic [3:0] wr_ptr_q, wr_ptr_d;
  logic [3:0] rd_ptr_q, rd_ptr_d;
  logic [4:0] ram_cnt_q, ram_cnt_d;
  logic       out_vld_q, out_vld_d;
  logic [7:0] rd_data_q, rd_data_d;
  prio_e      prio_q, prio_d;

  logic ram_empty, ram_full;
  logic fetch_req, wr_req, contested;
  logic do_fetch, do_write;

  assign ram_empty = (ram_cnt_q == 5'd0);
  assign ram_full  = (ram_cnt_q == 5'd16);

  // Fetch depends only on registered state, so WR_READY never sees RD_READY.
  assign fetch_req = !ram_empty && !out_vld_q;
  assign wr_req    = RST_N && WR_VALID && !ram_full;
  assign contested = fetch_req && wr_req;
  assign do_fetch  = fetch_req && (!wr_req || (prio_q == PRIO_RD));
  assign do_write  = wr_req && (!fetch_req || (prio_q == PRIO_WR));

  assign WR_READY = RST_N && !ram_full && (!fetch_req || (prio_q == PRIO_WR));

  assign A  = do_write ? wr_ptr_q : rd_ptr_q;
  assign D  = WR_DATA;
  assign WE = do_write;

  assign RD_VALID = out_vld_q;
  assign RD_DATA  = rd_data_q;
  assign COUNT    = ram_cnt_q + {4'd0, out_vld_q};
  assign FULL     = ram_full;
  assign EMPTY    = ram_empty && !out_vld_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ram_cnt_d = ram_cnt_q;
    out_vld_d = out_vld_q;
    rd_data_d = rd_data_q;
    prio_d    = prio_q;

    if (do_write) begin
      wr_ptr_d  = wr_ptr_q + 4'd1;
      ram_cnt_d = ram_cnt_q + 5'd1;
    end

    // A pop cannot coincide with a fetch, since a fetch needs an empty output register.
    if (do_fetch) begin
      rd_ptr_d  = rd_ptr_q + 4'd1;
      ram_cnt_d = ram_cnt_q - 5'd1;
      out_vld_d = 1'b1;
      rd_data_d = O;
    end else if (out_vld_q && RD_READY) begin
      out_vld_d = 1'b0;
    end

    if (contested) begin
      prio_d = (prio_q == PRIO_RD) ? PRIO_WR : PRIO_RD;
    end
  end

  always_ff @(posedge WCLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      out_vld_q <= 1'b0;
      rd_data_q <= '0;
      prio_q    <= PRIO_RD;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      out_vld_q <= out_vld_d;
      rd_data_q <= rd_data_d;
      prio_q    <= prio_d;
    end
  end

endmodule

// File: tb/tb_ram16x8s_fifo_ctrl.sv
// Bench for ram16x8s_fifo_ctrl with a behavioural 16x8 RAM and a byte scoreboard.
module tb_ram16x8s_fifo_ctrl;

  logic       WCLK = 1'b0;
  logic       RST_N;
  logic       WR_VALID;
  logic [7:0] WR_DATA;
  logic       WR_READY;
  logic       RD_VALID;
  logic [7:0] RD_DATA;
  logic       RD_READY;
  logic [3:0] A;
  logic [7:0] D;
  logic       WE;
  logic [7:0] O;
  logic [4:0] COUNT;
  logic       FULL;
  logic       EMPTY;

  int n_checks = 0;
  int n_errors = 0;
  int n_pop    = 0;

  logic [7:0] sb [$];
  logic [7:0] mem [16] = '{default: 8'hEE};

  always #5 WCLK = ~WCLK;

  ram16x8s_fifo_ctrl dut (
    .WCLK     (WCLK),
    .RST_N    (RST_N),
    .WR_VALID (WR_VALID),
    .WR_DATA  (WR_DATA),
    .WR_READY (WR_READY),
    .RD_VALID (RD_VALID),
    .RD_DATA  (RD_DATA),
    .RD_READY (RD_READY),
    .A        (A),
    .D        (D),
    .WE       (WE),
    .O        (O),
    .COUNT    (COUNT),
    .FULL     (FULL),
    .EMPTY    (EMPTY)
  );

  // RAM16X8S model: synchronous write, asynchronous read
  always @(posedge WCLK) if (WE) mem[A] <= D;
  assign O = mem[A];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Handshakes seen at the falling edge take effect at the following rising edge.
  always @(negedge WCLK) begin
    if (RST_N) begin
      if (WR_VALID && WR_READY) sb.push_back(WR_DATA);
      if (RD_VALID && RD_READY) begin
        n_pop++;
        if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
        else check("rd_data", {24'd0, RD_DATA}, {24'd0, sb.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge WCLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    WR_VALID = 1'b0;
    RD_READY = 1'b0;
    sb.delete();
    step();
    step();
    RST_N = 1'b1;
  endtask

  task automatic send(input int first, input int n, output int acc);
    bit ok;
    acc = 0;
    WR_VALID = 1'b1;
    WR_DATA = 8'(first);
    for (int c = 0; c < 400 && acc < n; c++) begin
      @(negedge WCLK);
      ok = WR_READY;
      step();
      if (ok) begin
        acc++;
        WR_DATA = 8'(first + acc);
      end
    end
    WR_VALID = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    RD_READY = 1'b1;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge WCLK);
      if (EMPTY) done = 1'b1;
    end
    check("drain_done", {31'd0, done}, 32'd1);
    check("drain_sb_empty", sb.size(), 32'd0);
    step();
    RD_READY = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int acc;
    int pop0;
    bit ok;
    bit seen;
    int exp_we [7] = '{0, 1, 1, 0, 1, 1, 0};

    // Reset held with a pending write
    RST_N = 1'b0;
    WR_VALID = 1'b1;
    WR_DATA = 8'h77;
    RD_READY = 1'b0;
    repeat (3) @(negedge WCLK);
    check("rst_we", {31'd0, WE}, 32'd0);
    check("rst_wr_ready", {31'd0, WR_READY}, 32'd0);
    check("rst_empty", {31'd0, EMPTY}, 32'd1);
    check("rst_count", {27'd0, COUNT}, 32'd0);
    check("rst_rd_valid", {31'd0, RD_VALID}, 32'd0);
    check("rst_full", {31'd0, FULL}, 32'd0);
    step();
    RST_N = 1'b1;
    WR_VALID = 1'b0;
    @(negedge WCLK);
    check("rel_wr_ready", {31'd0, WR_READY}, 32'd1);
    check("rel_no_write", {24'd0, mem[0]}, 32'hEE);

    // Write-to-read latency on an empty FIFO
    step();
    WR_VALID = 1'b1;
    WR_DATA = 8'hA5;
    @(negedge WCLK);
    check("lat_we", {31'd0, WE}, 32'd1);
    check("lat_addr", {28'd0, A}, 32'd0);
    check("lat_d", {24'd0, D}, 32'hA5);
    step();
    WR_VALID = 1'b0;
    @(negedge WCLK);
    check("lat_rv_t1", {31'd0, RD_VALID}, 32'd0);
    check("lat_fetch_we", {31'd0, WE}, 32'd0);
    step();
    @(negedge WCLK);
    check("lat_rv_t2", {31'd0, RD_VALID}, 32'd1);
    check("lat_rd_data", {24'd0, RD_DATA}, 32'hA5);
    check("lat_count", {27'd0, COUNT}, 32'd1);
    step();
    drain();

    // Fill to 17 then drain in order
    send(0, 17, acc);
    check("fill_accepted", acc, 32'd17);
    WR_VALID = 1'b1;
    WR_DATA = 8'h11;
    repeat (2) begin
      @(negedge WCLK);
      check("fill_full", {31'd0, FULL}, 32'd1);
      check("fill_count", {27'd0, COUNT}, 32'd17);
      check("fill_wr_ready", {31'd0, WR_READY}, 32'd0);
      check("fill_we", {31'd0, WE}, 32'd0);
      step();
    end
    WR_VALID = 1'b0;
    pop0 = n_pop;
    drain();
    check("fill_pops", n_pop - pop0, 32'd17);

    // Contention: prio=0, ram_cnt=3, out_vld=0, WR_VALID held high
    do_reset();
    WR_VALID = 1'b1;
    WR_DATA = 8'h90;
    step();
    WR_VALID = 1'b0;
    step();
    WR_VALID = 1'b1;
    WR_DATA = 8'h91;
    step();
    WR_DATA = 8'h92;
    step();
    WR_DATA = 8'h93;
    step();
    WR_VALID = 1'b0;
    @(negedge WCLK);
    check("cont_setup_count", {27'd0, COUNT}, 32'd4);
    check("cont_setup_rv", {31'd0, RD_VALID}, 32'd1);
    step();
    RD_READY = 1'b1;
    step();
    WR_VALID = 1'b1;
    WR_DATA = 8'h94;
    for (int i = 0; i < 7; i++) begin
      @(negedge WCLK);
      check($sformatf("cont_we_%0d", i), {31'd0, WE}, 32'(exp_we[i]));
      check($sformatf("cont_rdy_%0d", i), {31'd0, WR_READY}, 32'(exp_we[i]));
      ok = WR_READY;
      step();
      if (ok) WR_DATA = WR_DATA + 8'd1;
    end
    WR_VALID = 1'b0;
    drain();

    // Streaming with pointer wrap
    RD_READY = 1'b1;
    pop0 = n_pop;
    send(0, 40, acc);
    check("wrap_accepted", acc, 32'd40);
    drain();
    check("wrap_pops", n_pop - pop0, 32'd40);

    // Reset in the middle of a transfer
    do_reset();
    send(8'h50, 9, acc);
    check("mid_accepted", acc, 32'd9);
    @(negedge WCLK);
    check("mid_count9", {27'd0, COUNT}, 32'd9);
    step();
    RST_N = 1'b0;
    sb.delete();
    #1;
    check("mid_count0", {27'd0, COUNT}, 32'd0);
    check("mid_rv0", {31'd0, RD_VALID}, 32'd0);
    check("mid_empty", {31'd0, EMPTY}, 32'd1);
    check("mid_we0", {31'd0, WE}, 32'd0);
    step();
    RST_N = 1'b1;
    WR_VALID = 1'b1;
    WR_DATA = 8'h3C;
    @(negedge WCLK);
    check("mid_addr", {28'd0, A}, 32'd0);
    check("mid_we", {31'd0, WE}, 32'd1);
    step();
    WR_VALID = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge WCLK);
      if (RD_VALID) seen = 1'b1;
    end
    check("mid_rv_seen", {31'd0, seen}, 32'd1);
    check("mid_rd_data", {24'd0, RD_DATA}, 32'h3C);
    step();
    pop0 = n_pop;
    drain();
    check("mid_pops", n_pop - pop0, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
